fetch: RTL

Instruction fetch stage with integrated IF/ID pipeline register. It owns the program counter and issues in-order requests to instruction memory over a request/grant, response-valid handshake. It buffers returned instructions in a small slot queue and presents `InstrD`, `PCD` and `PCPlus4D` to the decode stage. It honours stall and flush from the hazard unit and redirect (branch/jump) from execute.

---
 rtl/fetch.sv | 101 ++++++++++
 1 files changed

// File: rtl/fetch.sv
// fetch: instruction fetch stage with in-order slot queue and IF/ID register
module fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   pc_f;
    logic [31:0]   slot_pc [DEPTH];
    logic [31:0]   slot_instr [DEPTH];
    logic [AW-1:0] head, tail, fill_idx;
    logic [CW-1:0] count, pend, drop_cnt;
    logic          head_alloc, head_filled, live_rsp, dead_rsp, alloc, bypass, pop;

    // Unfilled slots are always the youngest allocated ones, so "head filled" and
    // the oldest-unfilled index both follow from the pending-response count.
    always_comb begin
        head_alloc  = count != '0;
        head_filled = count > pend;
        live_rsp    = imem_rvalid && drop_cnt == '0;
        dead_rsp    = imem_rvalid && drop_cnt != '0;
        imem_req    = rst_n && !PCSrcE && ({1'b0, count} + {1'b0, drop_cnt} < {1'b0, DEPTH_C});
        alloc       = imem_req && imem_gnt;
        bypass      = head_alloc && !head_filled && live_rsp;
        pop         = !FlushD && !StallD && (head_filled || bypass);
        fill_idx    = tail - pend[AW-1:0];
    end

    assign imem_addr = pc_f;

    // Program counter, queue pointers and response accounting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_f     <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            pend     <= '0;
            drop_cnt <= '0;
        end else if (PCSrcE) begin
            pc_f     <= PCTargetE;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            pend     <= '0;
            drop_cnt <= drop_cnt + pend - CW'(live_rsp) - CW'(dead_rsp);
        end else begin
            if (alloc) begin
                pc_f <= pc_f + 32'd4;
                tail <= tail + AW'(1);
            end
            if (pop)
                head <= head + AW'(1);
            count    <= count + CW'(alloc) - CW'(pop);
            pend     <= pend + CW'(alloc) - CW'(live_rsp);
            drop_cnt <= drop_cnt - CW'(dead_rsp);
        end
    end

    // Slot payload: pc on allocation, instruction on a live response
    always_ff @(posedge clk) begin
        if (alloc)
            slot_pc[tail] <= pc_f;
        if (live_rsp)
            slot_instr[fill_idx] <= imem_rdata;
    end

    // IF/ID register: flush beats stall; otherwise pop the head or insert a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (FlushD || !StallD) begin
            InstrD   <= pop ? (head_filled ? slot_instr[head] : imem_rdata) : NOP_INSTR;
            PCD      <= pop ? slot_pc[head] : '0;
            PCPlus4D <= pop ? slot_pc[head] + 32'd4 : '0;
            ValidD   <= pop;
        end
    end
endmodule
